// File: rtl/grp_seq_pkg.sv
// Shared types and constants for the group register-transfer sequencer.
package grp_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StStep = 2'd2,
        StDone = 2'd3
    } grp_state_e;

    localparam int unsigned DefaultTimeoutCycles = 16;
    localparam logic [2:0]  LastReg              = 3'd7;

endpackage

// File: rtl/grp_tmo.sv
// Loadable down-counter for the memory no-answer timeout; expired_o flags the last allowed cycle.
module grp_tmo #(
    parameter int unsigned Cycles = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned Width = $clog2(Cycles + 1);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = Width'(Cycles);
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == Width'(1));

endmodule

// File: rtl/grp_seq.sv
// Group register-transfer sequencer: one memory handshake per register from first..R7.
// Optional no-answer timeout enabled by defining GRP_SEQ_TIMEOUT_EN.
module grp_seq
    import grp_seq_pkg::*;
`ifdef GRP_SEQ_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
)
`endif
(
    input  logic        clk_,
    input  logic        reset_,
    input  logic        start,
    input  logic        store,
    input  logic [2:0]  ir,
    input  logic [15:0] base_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [2:0]  reg_sel,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        done,
    output logic        alarm
);

    grp_state_e  state_q, state_d;
    logic [2:0]  index_q, index_d;
    logic [15:0] addr_q, addr_d;
    logic        store_q, store_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        alarm_q, alarm_d;
    logic        tmo_expired;

`ifdef GRP_SEQ_TIMEOUT_EN
    logic tmo_load;

    assign tmo_load = (state_q != StReq) && (state_d == StReq);

    grp_tmo #(
        .Cycles (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_i     (clk_),
        .rst_ni    (reset_),
        .load_i    (tmo_load),
        .run_i     (state_q == StReq),
        .expired_o (tmo_expired)
    );
`else
    assign tmo_expired = 1'b0;
`endif

    // Store data is captured on the edge entering REQ, so the register file must already be
    // addressed to the upcoming register: ir while starting, index+1 in a store STEP.
    always_comb begin
        reg_sel = index_q;
        if ((state_q == StIdle) && start) begin
            reg_sel = ir;
        end else if ((state_q == StStep) && store_q && (index_q != LastReg)) begin
            reg_sel = index_q + 3'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        store_d = store_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        alarm_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    store_d = store;
                    index_d = ir;
                    addr_d  = base_addr;
                    state_d = StReq;
                    if (store) begin
                        wdata_d = reg_rdata;
                    end
                end
            end
            StReq: begin
                // An ack on the expiring edge still completes the word normally.
                if (mem_ack) begin
                    if (!store_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = StStep;
                end else if (tmo_expired) begin
                    alarm_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StStep: begin
                if (index_q == LastReg) begin
                    state_d = StDone;
                end else begin
                    index_d = index_q + 3'd1;
                    addr_d  = addr_q + 16'd1;
                    state_d = StReq;
                    if (store_q) begin
                        wdata_d = reg_rdata;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_ or negedge reset_) begin
        if (!reset_) begin
            state_q <= StIdle;
            index_q <= 3'd0;
            addr_q  <= 16'd0;
            store_q <= 1'b0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            alarm_q <= alarm_d;
        end
    end

    assign mem_req   = (state_q == StReq);
    assign mem_we    = mem_req && store_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign reg_wr    = (state_q == StStep) && !store_q;
    assign reg_wdata = rdata_q;
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_grp_seq.sv
// Scoreboard bench for grp_seq: expected memory and register-file traffic is queued at start
// and checked cycle by cycle as the sequencer produces it.
module tb_grp_seq;

    logic        clk_ = 1'b0;
    logic        reset_;
    logic        start;
    logic        store;
    logic [2:0]  ir;
    logic [15:0] base_addr;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [2:0]  reg_sel;
    logic [15:0] reg_rdata;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic        busy;
    logic        done;
    logic        alarm;

    logic [15:0] regs    [8];
    logic [15:0] ld_data [8];

    logic [15:0] exp_addr_q [$];
    logic [15:0] exp_data_q [$];
    logic [2:0]  exp_sel_q  [$];
    logic [15:0] exp_rw_q   [$];

    int n_vec = 0;
    int n_err = 0;

    grp_seq dut (
        .clk_      (clk_),
        .reset_    (reset_),
        .start     (start),
        .store     (store),
        .ir        (ir),
        .base_addr (base_addr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .reg_sel   (reg_sel),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .done      (done),
        .alarm     (alarm)
    );

    always #5 clk_ = ~clk_;

    assign reg_rdata = regs[reg_sel];

    // One group transfer. Cycle 1 is the first cycle after the start edge.
    // start_again: cycle in which a stray start is driven (0 = none).
    // rst_word: word during whose second REQ cycle reset is pulsed (-1 = none).
    task automatic run_xfer(input logic st, input logic [2:0] first, input logic [15:0] base,
                            input int dly, input int start_again, input int rst_word);
        int   n;
        int   exp_done;
        int   word;
        int   waitc;
        logic prev_ack;
        n        = 8 - int'(first);
        exp_done = 1 + n * (2 + dly);
        word     = 0;
        waitc    = 0;
        prev_ack = 1'b0;
        for (int k = 0; k < n; k++) begin
            exp_addr_q.push_back(base + 16'(k));
            if (st) begin
                exp_data_q.push_back(regs[int'(first) + k]);
            end else begin
                exp_data_q.push_back(ld_data[k]);
                exp_sel_q.push_back(3'(int'(first) + k));
                exp_rw_q.push_back(ld_data[k]);
            end
        end
        @(negedge clk_);
        start     = 1'b1;
        store     = st;
        ir        = first;
        base_addr = base;
        @(negedge clk_);
        start     = 1'b0;
        store     = 1'($urandom);
        ir        = 3'($urandom);
        base_addr = 16'($urandom);
        for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
            if (cyc > 1) @(negedge clk_);
            mem_ack = 1'b0;
            start   = 1'b0;
            if (start_again == cyc) begin
                start     = 1'b1;
                ir        = 3'd0;
                base_addr = 16'h7777;
                store     = ~st;
            end
            n_vec++;
            if (busy !== (cyc <= exp_done)) begin
                n_err++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, cyc <= exp_done);
            end
            n_vec++;
            if (done !== (cyc == exp_done)) begin
                n_err++;
                $display("FAIL done cyc=%0d got=%b want=%b", cyc, done, cyc == exp_done);
            end
            n_vec++;
            if (alarm !== 1'b0) begin
                n_err++;
                $display("FAIL alarm cyc=%0d got=%b want=0", cyc, alarm);
            end
            n_vec++;
            if (prev_ack && (mem_req !== 1'b0)) begin
                n_err++;
                $display("FAIL req_gap cyc=%0d got mem_req=%b want=0", cyc, mem_req);
            end
            n_vec++;
            if (reg_wr !== (prev_ack && !st)) begin
                n_err++;
                $display("FAIL reg_wr cyc=%0d got=%b want=%b", cyc, reg_wr, prev_ack && !st);
            end
            if (reg_wr === 1'b1) begin
                n_vec++;
                if (exp_sel_q.size() == 0) begin
                    n_err++;
                    $display("FAIL reg_extra cyc=%0d got sel=%0d want no write", cyc, reg_sel);
                end else begin
                    if (reg_sel !== exp_sel_q[0] || reg_wdata !== exp_rw_q[0]) begin
                        n_err++;
                        $display("FAIL reg_write cyc=%0d got R%0d=%h want R%0d=%h", cyc,
                                 reg_sel, reg_wdata, exp_sel_q[0], exp_rw_q[0]);
                    end
                    regs[reg_sel] = reg_wdata;
                    void'(exp_sel_q.pop_front());
                    void'(exp_rw_q.pop_front());
                end
            end
            if (mem_req === 1'b1) begin
                n_vec++;
                if (exp_addr_q.size() == 0) begin
                    n_err++;
                    $display("FAIL req_extra cyc=%0d got addr=%h want no request", cyc, mem_addr);
                end else begin
                    if (mem_addr !== exp_addr_q[0] || mem_we !== st) begin
                        n_err++;
                        $display("FAIL req_addr cyc=%0d got addr=%h we=%b want addr=%h we=%b",
                                 cyc, mem_addr, mem_we, exp_addr_q[0], st);
                    end
                    if (st) begin
                        n_vec++;
                        if (mem_wdata !== exp_data_q[0]) begin
                            n_err++;
                            $display("FAIL wdata cyc=%0d got=%h want=%h", cyc, mem_wdata,
                                     exp_data_q[0]);
                        end
                    end
                    if (rst_word == word && waitc == 1) begin
                        #2 reset_ = 1'b0;
                        #1;
                        n_vec++;
                        if ({mem_req, mem_we, mem_addr, mem_wdata, reg_sel, reg_wr, reg_wdata,
                             busy, done, alarm} !== '0) begin
                            n_err++;
                            $display("FAIL async_reset got req=%b addr=%h wd=%h sel=%0d rd=%h busy=%b done=%b want all 0",
                                     mem_req, mem_addr, mem_wdata, reg_sel, reg_wdata, busy, done);
                        end
                        @(posedge clk_);
                        #1;
                        n_vec++;
                        if (busy !== 1'b0 || done !== 1'b0) begin
                            n_err++;
                            $display("FAIL reset_hold got busy=%b done=%b want 0 0", busy, done);
                        end
                        @(negedge clk_);
                        reset_ = 1'b1;
                        exp_addr_q.delete();
                        exp_data_q.delete();
                        exp_sel_q.delete();
                        exp_rw_q.delete();
                        return;
                    end
                    if (waitc == dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = st ? 16'hDEAD : exp_data_q[0];
                        void'(exp_addr_q.pop_front());
                        void'(exp_data_q.pop_front());
                        word++;
                        waitc = 0;
                    end else begin
                        mem_rdata = 16'($urandom);
                        waitc++;
                    end
                end
            end
            prev_ack = mem_ack;
        end
        n_vec++;
        if (exp_addr_q.size() != 0 || exp_sel_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover got %0d words %0d reg writes outstanding want 0 0",
                     exp_addr_q.size(), exp_sel_q.size());
            exp_addr_q.delete();
            exp_data_q.delete();
            exp_sel_q.delete();
            exp_rw_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_ = 1'b1;
        #2 reset_ = 1'b0;
        #1;
        n_vec++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, reg_sel, reg_wr, reg_wdata, busy, done,
             alarm} !== '0) begin
            n_err++;
            $display("FAIL reset_state got req=%b addr=%h sel=%0d busy=%b done=%b want all 0",
                     mem_req, mem_addr, reg_sel, busy, done);
        end
        repeat (2) @(negedge clk_);
        reset_ = 1'b1;
    endtask

    task automatic test_store();
        regs[5] = 16'h1111;
        regs[6] = 16'h2222;
        regs[7] = 16'h3333;
        run_xfer(1'b1, 3'd5, 16'h0100, 0, 0, -1);
    endtask

    task automatic test_load_wrap();
        ld_data[0] = 16'hAAAA;
        ld_data[1] = 16'h5555;
        run_xfer(1'b0, 3'd6, 16'hFFFF, 0, 0, -1);
        n_vec++;
        if (regs[6] !== 16'hAAAA || regs[7] !== 16'h5555) begin
            n_err++;
            $display("FAIL load_regs got R6=%h R7=%h want aaaa 5555", regs[6], regs[7]);
        end
    endtask

    task automatic test_ack_wait();
        ld_data[0] = 16'hC3C3;
        run_xfer(1'b0, 3'd7, 16'h2040, 3, 0, -1);
    endtask

    task automatic test_start_ignored();
        for (int k = 0; k < 8; k++) regs[k] = 16'h4000 + 16'(k * 3);
        run_xfer(1'b1, 3'd2, 16'h0300, 1, 2, -1);
    endtask

    task automatic test_async_reset();
        run_xfer(1'b1, 3'd4, 16'h0500, 2, 0, 1);
        for (int k = 0; k < 8; k++) ld_data[k] = 16'($urandom);
        run_xfer(1'b0, 3'd0, 16'h0A00, 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        run_xfer(1'b1, 3'd3, 16'hFFFE, 0, 0, -1);
        ld_data[0] = 16'h0F0F;
        ld_data[1] = 16'hF0F0;
        run_xfer(1'b0, 3'd6, 16'h1234, 1, 0, -1);
    endtask

`ifdef GRP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int  req_cycles;
        bit  dropped;
        req_cycles = 0;
        dropped    = 1'b0;
        @(negedge clk_);
        start     = 1'b1;
        store     = 1'b0;
        ir        = 3'd3;
        base_addr = 16'h0800;
        @(negedge clk_);
        start = 1'b0;
        for (int cyc = 1; cyc <= 40 && !dropped; cyc++) begin
            if (cyc > 1) @(negedge clk_);
            n_vec++;
            if (done !== 1'b0 || reg_wr !== 1'b0) begin
                n_err++;
                $display("FAIL tmo_quiet cyc=%0d got done=%b reg_wr=%b want 0 0", cyc, done,
                         reg_wr);
            end
            if (mem_req === 1'b1) begin
                req_cycles++;
            end else begin
                dropped = 1'b1;
                n_vec++;
                if (req_cycles != 16 || alarm !== 1'b1 || busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL tmo_expire got req_cycles=%0d alarm=%b busy=%b want 16 1 0",
                             req_cycles, alarm, busy);
                end
            end
        end
        n_vec++;
        if (!dropped) begin
            n_err++;
            $display("FAIL tmo_bound got mem_req still high want drop within 40 cycles");
        end
        @(negedge clk_);
        n_vec++;
        if (alarm !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_pulse got alarm=%b done=%b want 0 0", alarm, done);
        end
    endtask
`else
    task automatic test_long_wait();
        ld_data[0] = 16'h6789;
        run_xfer(1'b0, 3'd7, 16'h0042, 20, 0, -1);
    endtask
`endif

    initial begin
        start     = 1'b0;
        store     = 1'b0;
        ir        = 3'd0;
        base_addr = 16'd0;
        mem_ack   = 1'b0;
        mem_rdata = 16'd0;
        for (int k = 0; k < 8; k++) begin
            regs[k]    = 16'h0101 * 16'(k);
            ld_data[k] = 16'd0;
        end
        test_reset();
        test_store();
        test_load_wrap();
        test_ack_wait();
        test_start_ignored();
        test_async_reset();
        test_back_to_back();
`ifdef GRP_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_long_wait();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
